// File: rtl/apb_spi_arbiter.sv
// Two-requester round-robin APB master that shares one APB-attached SPI controller.
// Sequences SETUP/ACCESS, returns per-command read data or error, and aborts stalled ACCESS phases.
module apb_spi_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t            state, state_nxt;
  logic              last, gnt, pick, accept, done_ok, time_out, rsp_err;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rsp_rdata;

  // Handshake: a requester holds valid and its fields stable until it sees ready;
  // ready is a one-cycle pulse and the command is captured on the edge that ends it.
  always_comb begin
    pick      = (req0_valid && req1_valid) ? ~last : req1_valid;
    done_ok   = (state == ACCESS) && PREADY;
    time_out  = (state == ACCESS) && !PREADY && (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    accept    = !PRESET && (req0_valid || req1_valid) && ((state == IDLE) || done_ok);
    rsp_err   = time_out | PSLVERR;
    rsp_rdata = (rsp_err || PWRITE) ? '0 : PRDATA;
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (done_ok)       state_nxt = accept ? SETUP : IDLE;
        else if (time_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = accept && !pick;
  assign req1_ready = accept && pick;
  assign PSEL       = (state != IDLE);
  assign PENABLE    = (state == ACCESS);
  assign busy       = PSEL;
  assign dbg_state  = state;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      last       <= 1'b1;
      gnt        <= 1'b0;
      cnt        <= '0;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
      if (accept) begin
        gnt    <= pick;
        last   <= pick;
        PADDR  <= pick ? req1_addr  : req0_addr;
        PWRITE <= pick ? req1_write : req0_write;
        PWDATA <= pick ? req1_wdata : req0_wdata;
      end
      if (state == SETUP)
        cnt <= '0;
      else if ((state == ACCESS) && !PREADY)
        cnt <= cnt + 1'b1;
      // The response belongs to the command in flight, not the one just accepted.
      if (done_ok || time_out) begin
        if (gnt) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= rsp_rdata;
          rsp1_err   <= rsp_err;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= rsp_rdata;
          rsp0_err   <= rsp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_spi_arbiter.sv
// Bench for apb_spi_arbiter: command driver, APB slave responder and response scoreboard
// share one per-cycle tick so every check runs in the single stimulus process.
module tb_apb_spi_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 6;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  logic          PCLK, PRESET;
  logic          req0_valid, req0_write, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_write, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR, busy;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [1:0]    dbg_state;

  apb_spi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  int pass_cnt = 0;
  int check_cnt = 0;

  // scoreboard and monitor state
  logic [DW:0]         exp_q0[$];
  logic [DW:0]         exp_q1[$];
  logic [AW+DW:0]      apb_q[$];
  logic [AW+DW:0]      cur_apb;
  int                  gnt_log[$];
  int                  setup_cyc[$];
  cmd_t                c0_q[$];
  cmd_t                c1_q[$];
  logic                m_last = 1'b1;
  logic                seen0, seen1;
  int cyc = 0, setups = 0, acc_cycles = 0, stab_err = 0;
  int rsp0_cnt = 0, rsp1_cnt = 0, acc_at = 0, rsp_at = 0;

  // slave responder configuration
  int   slv_wait = 0;
  int   acc_n = 0;
  logic slv_err = 1'b0;
  logic slv_force = 1'b0;

  task automatic tick();
    logic          g, w, e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW:0]   exp_r;
    logic [AW+DW:0] exp_a;
    @(negedge PCLK);
    cyc++;
    seen0 = req0_ready;
    seen1 = req1_ready;
    if (PRESET) begin
      exp_q0.delete();
      exp_q1.delete();
      apb_q.delete();
      m_last = 1'b1;
    end else begin
      if (seen0 || seen1) begin
        g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        check_cnt++;
        if ({seen1, seen0} !== (g ? 2'b10 : 2'b01))
          $display("FAIL grant: ready=%b expected=%b", {seen1, seen0}, (g ? 2'b10 : 2'b01));
        else pass_cnt++;
        w = g ? req1_write : req0_write;
        a = g ? req1_addr  : req0_addr;
        d = g ? req1_wdata : req0_wdata;
        e = slv_err || (slv_wait >= TO);
        apb_q.push_back({w, a, d});
        exp_r = {e, (e || w) ? {DW{1'b0}} : (32'hA5A5_0000 | (a >> 2))};
        if (g) exp_q1.push_back(exp_r);
        else   exp_q0.push_back(exp_r);
        gnt_log.push_back(int'(g));
        m_last = g;
        acc_at = cyc;
      end
      if (busy !== PSEL) stab_err++;
      if (PSEL && !PENABLE) begin
        setups++;
        setup_cyc.push_back(cyc);
        cur_apb = {PWRITE, PADDR, PWDATA};
        check_cnt++;
        if (apb_q.size() == 0) $display("FAIL apb_setup: unexpected SETUP addr=%h", PADDR);
        else begin
          exp_a = apb_q.pop_front();
          if (cur_apb !== exp_a) $display("FAIL apb_setup: got=%h expected=%h", cur_apb, exp_a);
          else pass_cnt++;
        end
      end
      if (PSEL && PENABLE) begin
        acc_cycles++;
        if ({PWRITE, PADDR, PWDATA} !== cur_apb) stab_err++;
      end
      if (rsp0_valid) begin
        rsp0_cnt++;
        rsp_at = cyc;
        check_cnt++;
        if (exp_q0.size() == 0) $display("FAIL rsp0: unexpected response err=%b rdata=%h", rsp0_err, rsp0_rdata);
        else begin
          exp_r = exp_q0.pop_front();
          if ({rsp0_err, rsp0_rdata} !== exp_r) $display("FAIL rsp0: got=%h expected=%h", {rsp0_err, rsp0_rdata}, exp_r);
          else pass_cnt++;
        end
      end
      if (rsp1_valid) begin
        rsp1_cnt++;
        rsp_at = cyc;
        check_cnt++;
        if (exp_q1.size() == 0) $display("FAIL rsp1: unexpected response err=%b rdata=%h", rsp1_err, rsp1_rdata);
        else begin
          exp_r = exp_q1.pop_front();
          if ({rsp1_err, rsp1_rdata} !== exp_r) $display("FAIL rsp1: got=%h expected=%h", {rsp1_err, rsp1_rdata}, exp_r);
          else pass_cnt++;
        end
      end
    end
    @(posedge PCLK);
    #1;
    if (PSEL && PENABLE) begin
      PREADY = (acc_n == slv_wait);
      acc_n++;
    end else begin
      acc_n = 0;
      PREADY = slv_force;
    end
    PSLVERR = slv_err && PREADY;
    PRDATA = 32'hA5A5_0000 | (PADDR >> 2);
  endtask

  // driver tasks
  task automatic load_ports();
    req0_valid = (c0_q.size() > 0);
    if (req0_valid) {req0_write, req0_addr, req0_wdata} = c0_q[0];
    req1_valid = (c1_q.size() > 0);
    if (req1_valid) {req1_write, req1_addr, req1_wdata} = c1_q[0];
  endtask

  task automatic run_cmds();
    int guard = 0;
    load_ports();
    while ((c0_q.size() > 0 || c1_q.size() > 0) && guard < 300) begin
      tick();
      guard++;
      if (seen0) void'(c0_q.pop_front());
      if (seen1) void'(c1_q.pop_front());
      load_ports();
    end
    if (guard >= 300) begin
      check_cnt++;
      $display("FAIL accept_timeout: %0d/%0d commands left", c0_q.size(), c1_q.size());
      c0_q.delete();
      c1_q.delete();
      load_ports();
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0 || apb_q.size() > 0 || busy) && guard < 100) begin
      tick();
      guard++;
    end
    check_cnt++;
    if (guard >= 100) $display("FAIL drain_timeout: q0=%0d q1=%0d busy=%b", exp_q0.size(), exp_q1.size(), busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    {req0_write, req0_addr, req0_wdata} = '0;
    {req1_write, req1_addr, req1_wdata} = '0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    tick();
    tick();
    check_cnt++;
    if ({PSEL, PENABLE, PWRITE, busy} !== 4'b0000) $display("FAIL reset_ctrl: got=%b expected=0000", {PSEL, PENABLE, PWRITE, busy});
    else pass_cnt++;
    check_cnt++;
    if ({PADDR, PWDATA} !== '0) $display("FAIL reset_addr_data: got=%h expected=0", {PADDR, PWDATA});
    else pass_cnt++;
    check_cnt++;
    if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got=%b expected=00", {req0_ready, req1_ready});
    else pass_cnt++;
    check_cnt++;
    if ({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err} !== 4'b0000) $display("FAIL reset_rsp: got=%b expected=0000", {rsp0_valid, rsp0_err, rsp1_valid, rsp1_err});
    else pass_cnt++;
    check_cnt++;
    if ({rsp0_rdata, rsp1_rdata} !== '0) $display("FAIL reset_rdata: got=%h expected=0", {rsp0_rdata, rsp1_rdata});
    else pass_cnt++;
    check_cnt++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got=%0d expected=0", dbg_state);
    else pass_cnt++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int base_rsp0 = rsp0_cnt, base_rsp1 = rsp1_cnt;
    gnt_log.delete();
    setup_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      c0_q.push_back('{w: 1'b1, a: 32'h100 + 32'(i * 4), d: $urandom_range(0, 32'h7FFF_FFFF)});
      c1_q.push_back('{w: 1'b1, a: 32'h200 + 32'(i * 4), d: $urandom_range(0, 32'h7FFF_FFFF)});
    end
    run_cmds();
    wait_drain();
    check_cnt++;
    if (gnt_log.size() != 8) $display("FAIL b2b_grants: got=%0d expected=8", gnt_log.size());
    else pass_cnt++;
    for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
      check_cnt++;
      if (gnt_log[i] != (i % 2)) $display("FAIL b2b_order[%0d]: got=%0d expected=%0d", i, gnt_log[i], i % 2);
      else pass_cnt++;
    end
    for (int i = 1; i < setup_cyc.size(); i++) begin
      check_cnt++;
      if (setup_cyc[i] - setup_cyc[i-1] != 2) $display("FAIL b2b_spacing[%0d]: got=%0d expected=2", i, setup_cyc[i] - setup_cyc[i-1]);
      else pass_cnt++;
    end
    check_cnt++;
    if ((rsp0_cnt - base_rsp0) != 4 || (rsp1_cnt - base_rsp1) != 4)
      $display("FAIL b2b_rsp_count: got=%0d,%0d expected=4,4", rsp0_cnt - base_rsp0, rsp1_cnt - base_rsp1);
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    int base_rsp0 = rsp0_cnt, base_rsp1 = rsp1_cnt;
    setups = 0;
    acc_cycles = 0;
    c0_q.push_back('{w: 1'b0, a: 32'h04, d: 32'h0});
    run_cmds();
    wait_drain();
    check_cnt++;
    if (setups != 1 || acc_cycles != 1) $display("FAIL single_phases: setup=%0d access=%0d expected=1,1", setups, acc_cycles);
    else pass_cnt++;
    check_cnt++;
    if ((rsp0_cnt - base_rsp0) != 1 || (rsp1_cnt - base_rsp1) != 0)
      $display("FAIL single_rsp_count: got=%0d,%0d expected=1,0", rsp0_cnt - base_rsp0, rsp1_cnt - base_rsp1);
    else pass_cnt++;
    check_cnt++;
    if (rsp_at - acc_at != 3) $display("FAIL single_latency: got=%0d expected=3", rsp_at - acc_at);
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    slv_wait = 5;
    acc_cycles = 0;
    stab_err = 0;
    c1_q.push_back('{w: 1'b0, a: 32'h40, d: 32'h1234});
    run_cmds();
    wait_drain();
    slv_wait = 0;
    check_cnt++;
    if (acc_cycles != 6) $display("FAIL wait_access_len: got=%0d expected=6", acc_cycles);
    else pass_cnt++;
    check_cnt++;
    if (stab_err != 0) $display("FAIL wait_stable: got=%0d expected=0", stab_err);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int base_rsp0, base_rsp1;
    slv_wait = 1000;
    acc_cycles = 0;
    c0_q.push_back('{w: 1'b0, a: 32'h80, d: 32'h0});
    run_cmds();
    wait_drain();
    slv_wait = 0;
    check_cnt++;
    if (acc_cycles != TO) $display("FAIL timeout_len: got=%0d expected=%0d", acc_cycles, TO);
    else pass_cnt++;
    check_cnt++;
    if (dbg_state !== 2'd0 || busy !== 1'b0) $display("FAIL timeout_idle: state=%0d busy=%b expected=0,0", dbg_state, busy);
    else pass_cnt++;
    base_rsp0 = rsp0_cnt;
    base_rsp1 = rsp1_cnt;
    slv_force = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    slv_force = 1'b0;
    tick();
    check_cnt++;
    if (rsp0_cnt != base_rsp0 || rsp1_cnt != base_rsp1 || PSEL !== 1'b0)
      $display("FAIL timeout_late_ready: rsp=%0d,%0d psel=%b expected no change", rsp0_cnt - base_rsp0, rsp1_cnt - base_rsp1, PSEL);
    else pass_cnt++;
  endtask

  task automatic test_slverr();
    int base_rsp1 = rsp1_cnt;
    slv_err = 1'b1;
    c1_q.push_back('{w: 1'b1, a: 32'h10, d: 32'hDEAD_BEEF});
    run_cmds();
    wait_drain();
    slv_err = 1'b0;
    c1_q.push_back('{w: 1'b0, a: 32'h08, d: 32'h0});
    run_cmds();
    wait_drain();
    check_cnt++;
    if ((rsp1_cnt - base_rsp1) != 2) $display("FAIL slverr_rsp_count: got=%0d expected=2", rsp1_cnt - base_rsp1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int base_rsp0, base_rsp1;
    slv_wait = 1000;
    c0_q.push_back('{w: 1'b0, a: 32'h0C, d: 32'h0});
    run_cmds();
    while (!PENABLE && guard < 5) begin
      tick();
      guard++;
    end
    check_cnt++;
    if (PENABLE !== 1'b1) $display("FAIL rstmid_access: penable=%b expected=1", PENABLE);
    else pass_cnt++;
    base_rsp0 = rsp0_cnt;
    base_rsp1 = rsp1_cnt;
    PRESET = 1'b1;
    #1;
    check_cnt++;
    if ({PSEL, PENABLE} !== 2'b00) $display("FAIL rstmid_async: psel_penable=%b expected=00", {PSEL, PENABLE});
    else pass_cnt++;
    slv_wait = 0;
    tick();
    tick();
    PRESET = 1'b0;
    tick();
    tick();
    check_cnt++;
    if (rsp0_cnt != base_rsp0 || rsp1_cnt != base_rsp1) $display("FAIL rstmid_no_rsp: got=%0d,%0d new responses expected=0,0", rsp0_cnt - base_rsp0, rsp1_cnt - base_rsp1);
    else pass_cnt++;
    gnt_log.delete();
    c1_q.push_back('{w: 1'b0, a: 32'h20, d: 32'h0});
    c0_q.push_back('{w: 1'b0, a: 32'h24, d: 32'h0});
    run_cmds();
    wait_drain();
    check_cnt++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 1)
      $display("FAIL rstmid_order: got=%p expected=0,1", gnt_log);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_read();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
